// File: rtl/alu_seq_ctrl.sv
// Sequential ALU control: per-instruction execute-step schedules
// with multi-cycle shifts, illegal detection and back-to-back issue.
module alu_seq_ctrl #(
  parameter int OPCODE_WIDTH = 4,
  parameter int FUNC_WIDTH   = 4,
  parameter int SHAMT_WIDTH  = 3,
  parameter int CTRL_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNC_WIDTH-1:0]   func,
  input  logic [SHAMT_WIDTH-1:0]  shamt,
  output logic                    busy,
  output logic                    done,
  output logic [CTRL_WIDTH-1:0]   alu_ctrl,
  output logic                    alu_en,
  output logic [2:0]              step,
  output logic                    illegal
);

  localparam logic [CTRL_WIDTH-1:0] C_ADD = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] C_SUB = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] C_AND = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] C_OR  = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] C_XOR = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] C_LSL = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] C_LSR = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] C_ASR = CTRL_WIDTH'(7);

  localparam logic [SHAMT_WIDTH-1:0] SH_ZERO = '0;
  localparam logic [SHAMT_WIDTH-1:0] SH_ONE  = SHAMT_WIDTH'(1);
  localparam logic [SHAMT_WIDTH-1:0] SH_TWO  = SHAMT_WIDTH'(2);

  // Schedule kind of the instruction currently executing
  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_PUSH,
    S_POP,
    S_RET,
    S_RCALL,
    S_SHIFT
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [CTRL_WIDTH-1:0]   r_ctrl;
  logic                    r_en;
  logic [2:0]              r_step;
  logic                    r_ill;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic [CTRL_WIDTH-1:0]   r_shctrl;

  state_t                  w_nstate;
  logic                    w_nbusy;
  logic                    w_ndone;
  logic [CTRL_WIDTH-1:0]   w_nctrl;
  logic                    w_nen;
  logic [2:0]              w_nstep;
  logic                    w_nill;
  logic [SHAMT_WIDTH-1:0]  w_ncnt;
  logic [CTRL_WIDTH-1:0]   w_nshctrl;

  logic [3:0]              w_opc;
  logic [3:0]              w_fn;
  logic                    w_rtype;
  logic                    w_bad;
  logic                    w_rtype_ok;
  logic                    w_accept;

  state_t                  w_dstate;
  logic [CTRL_WIDTH-1:0]   w_dctrl;
  logic                    w_den;
  logic                    w_ddone;
  logic                    w_dill;

  assign w_opc      = opcode[3:0];
  assign w_fn       = func[3:0];
  assign w_rtype    = (w_opc == 4'd0);
  assign w_bad      = (w_opc == 4'd7) ||
                      (w_rtype && (w_fn == 4'd0 ||
                                   w_fn == 4'd6 ||
                                   w_fn == 4'd7));
  assign w_rtype_ok = w_rtype && !w_bad;
  assign w_accept   = start && (!r_busy || r_done);

  // Decode of the incoming instruction into its first-step behaviour
  always_comb begin
    w_dstate = S_ONE;
    w_dctrl  = C_ADD;
    w_den    = 1'b1;
    w_ddone  = 1'b1;
    w_dill   = 1'b0;
    unique case (1'b1)
      w_bad: begin
        w_den  = 1'b0;
        w_dill = 1'b1;
      end
      w_rtype_ok: begin
        case (w_fn)
          4'd1:         w_dctrl = C_ADD;
          4'd2, 4'd15:  w_dctrl = C_SUB;
          4'd3:         w_dctrl = C_AND;
          4'd4:         w_dctrl = C_OR;
          4'd5:         w_dctrl = C_XOR;
          4'd8, 4'd10: begin
            w_dstate = S_PUSH;
            w_den    = 1'b0;
            w_ddone  = 1'b0;
          end
          4'd9, 4'd11: begin
            w_dstate = S_POP;
            w_den    = 1'b0;
            w_ddone  = 1'b0;
          end
          4'd12: begin
            w_dstate = S_SHIFT;
            w_dctrl  = C_LSR;
          end
          4'd13: begin
            w_dstate = S_SHIFT;
            w_dctrl  = C_LSL;
          end
          4'd14: begin
            w_dstate = S_SHIFT;
            w_dctrl  = C_ASR;
          end
          default: w_dctrl = C_ADD;
        endcase
      end
      default: begin
        case (w_opc)
          4'd1, 4'd3: w_dctrl = C_SUB;
          4'd4:       w_dctrl = C_AND;
          4'd5:       w_dctrl = C_OR;
          4'd6:       w_dctrl = C_XOR;
          4'd9: begin
            w_dstate = S_RET;
            w_ddone  = 1'b0;
          end
          4'd10: begin
            w_dstate = S_RCALL;
            w_den    = 1'b0;
            w_ddone  = 1'b0;
          end
          default:    w_dctrl = C_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    w_nstate  = S_IDLE;
    w_nbusy   = 1'b0;
    w_ndone   = 1'b0;
    w_nctrl   = '0;
    w_nen     = 1'b0;
    w_nstep   = 3'd0;
    w_nill    = 1'b0;
    w_ncnt    = r_cnt;
    w_nshctrl = r_shctrl;
    if (w_accept) begin
      w_nstate  = w_dstate;
      w_nbusy   = 1'b1;
      w_nstep   = 3'd2;
      w_nen     = w_den;
      w_ndone   = w_ddone;
      w_nill    = w_dill;
      w_ncnt    = shamt;
      w_nshctrl = w_dctrl;
      // Shifts of 0 or 1 finish in their first cycle
      if (w_dstate == S_SHIFT) begin
        w_nen   = (shamt != SH_ZERO);
        w_ndone = (shamt <= SH_ONE);
        if (shamt <= SH_ONE) w_nstate = S_ONE;
      end
      w_nctrl = w_nen ? w_dctrl : '0;
    end else if (r_busy && !r_done) begin
      w_nstate = r_state;
      w_nbusy  = 1'b1;
      w_nen    = 1'b1;
      unique case (r_state)
        S_PUSH: begin
          w_nstep = 3'd3;
          w_nctrl = C_SUB;
          w_ndone = 1'b1;
        end
        S_POP, S_RET: begin
          w_nstep = 3'd3;
          w_nctrl = C_ADD;
          w_ndone = 1'b1;
        end
        S_RCALL: begin
          w_nstep = r_step + 3'd1;
          w_nctrl = (r_step == 3'd3) ? C_ADD : C_SUB;
          w_ndone = (r_step == 3'd4);
        end
        S_SHIFT: begin
          w_nstep = 3'd2;
          w_ncnt  = r_cnt - SH_ONE;
          w_nctrl = r_shctrl;
          w_ndone = (r_cnt == SH_TWO);
        end
        default: begin
          w_nstate = S_IDLE;
          w_nbusy  = 1'b0;
          w_nen    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ctrl   <= '0;
      r_en     <= 1'b0;
      r_step   <= 3'd0;
      r_ill    <= 1'b0;
      r_cnt    <= '0;
      r_shctrl <= '0;
    end else begin
      r_state  <= w_nstate;
      r_busy   <= w_nbusy;
      r_done   <= w_ndone;
      r_ctrl   <= w_nctrl;
      r_en     <= w_nen;
      r_step   <= w_nstep;
      r_ill    <= w_nill;
      r_cnt    <= w_ncnt;
      r_shctrl <= w_nshctrl;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign alu_ctrl = r_ctrl;
  assign alu_en   = r_en;
  assign step     = r_step;
  assign illegal  = r_ill;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus random issue
// against a schedule-table reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] opcode;
  logic [3:0] func;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [2:0] alu_ctrl;
  logic       alu_en;
  logic [2:0] step;
  logic       illegal;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .func     (func),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .alu_ctrl (alu_ctrl),
    .alu_en   (alu_en),
    .step     (step),
    .illegal  (illegal)
  );

  // {busy, done, ctrl[2:0], en, step[2:0], illegal}
  typedef logic [9:0] ov_t;
  ov_t obs;
  assign obs = {busy, done, alu_ctrl, alu_en, step, illegal};

  ov_t cur;
  ov_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  function automatic ov_t ent(int st, int c, bit dn, bit il);
    bit en;
    en = (c >= 0);
    return {1'b1, dn, (en ? 3'(c) : 3'd0), en, 3'(st), il};
  endfunction

  // Per-instruction schedule; -1 marks a cycle with alu_en=0
  function automatic void load(int op, int fn, int sh);
    int c[$];
    bit il;
    bit sft;
    il  = 1'b0;
    sft = 1'b0;
    q.delete();
    if (op == 7 || (op == 0 && (fn == 0 || fn == 6 || fn == 7))) begin
      c  = '{-1};
      il = 1'b1;
    end else if (op == 0) begin
      case (fn)
        1:        c = '{0};
        2, 15:    c = '{1};
        3:        c = '{2};
        4:        c = '{3};
        5:        c = '{4};
        8, 10:    c = '{-1, 1};
        9, 11:    c = '{-1, 0};
        default: begin
          sft = 1'b1;
          if (sh == 0) c = '{-1};
          else repeat (sh) c.push_back(fn == 12 ? 6 : (fn == 13 ? 5 : 7));
        end
      endcase
    end else begin
      case (op)
        1, 3:    c = '{1};
        4:       c = '{2};
        5:       c = '{3};
        6:       c = '{4};
        9:       c = '{0, 0};
        10:      c = '{-1, 1, 0, 1};
        default: c = '{0};
      endcase
    end
    foreach (c[i])
      q.push_back(ent(sft ? 2 : 2 + i, c[i], i == c.size() - 1, il));
  endfunction

  // One clock of stimulus; advances the reference model
  task automatic drive(bit s, int op, int fn, int sh);
    bit acc;
    start  = s;
    opcode = 4'(op);
    func   = 4'(fn);
    shamt  = 3'(sh);
    acc    = s && (!cur[9] || cur[8]);
    @(posedge clk);
    #1;
    if (acc) load(op, fn, sh);
    if (q.size() > 0) cur = q.pop_front();
    else cur = '0;
    start  = 1'b0;
    opcode = 4'($urandom);
    func   = 4'($urandom);
    shamt  = 3'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start  = 1'b1;
      opcode = 4'd2;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_chk++;
      if (obs !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold %0d: got %b want %b", i, obs, 10'd0);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    cur   = '0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2, 0, 0);
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL reset_idle %0d: got %b want %b", i, obs, cur);
      end
    end
  endtask

  task automatic test_rcall();
    drive(1, 10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL rcall %0d: got %b want %b", i, obs, cur);
      end
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_shift();
    drive(1, 0, 12, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL lsr5 %0d: got %b want %b", i, obs, cur);
      end
      drive(0, 0, 0, 0);
    end
    drive(1, 0, 12, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL lsr0 %0d: got %b want %b", i, obs, cur);
      end
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 2, 0, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL b2b_addi: got %b want %b", obs, cur);
    end
    drive(1, 0, 5, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL b2b_xor: got %b want %b", obs, cur);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b want %b", obs, cur);
    end
  endtask

  task automatic test_ignored_start();
    drive(1, 0, 8, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL push_ign %0d: got %b want %b", i, obs, cur);
      end
      drive(i == 0, 2, 0, 0);
    end
  endtask

  task automatic test_illegal();
    drive(1, 7, 0, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL illegal_op7: got %b want %b", obs, cur);
    end
    drive(1, 0, 6, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL illegal_fn6: got %b want %b", obs, cur);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL illegal_idle: got %b want %b", obs, cur);
    end
  endtask

  task automatic test_reset_abort();
    drive(1, 10, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_chk++;
    if (obs !== cur) begin
      n_fail++;
      $display("FAIL abort_step4: got %b want %b", obs, cur);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_async: got %b want %b", obs, 10'd0);
    end
    cur = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL abort_nodone %0d: got %b want %b", i, obs, cur);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      @(negedge clk);
      n_chk++;
      if (obs !== cur) begin
        n_fail++;
        $display("FAIL random %0d: got %b want %b", i, obs, cur);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    func   = 4'd0;
    shamt  = 3'd0;
    cur    = '0;
    test_reset();
    test_rcall();
    test_shift();
    test_back_to_back();
    test_ignored_start();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
